// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl
// Turn and score controller for the card-matching memory game. It runs the
// board datapath through level req / pulsed done handshakes (show, hide,
// shuffle, random pick, verify), keeps a per-turn countdown, rotates players
// round-robin, tracks scores and remaining pairs, and latches the winner set.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              start a game from IDLE / return to IDLE from DONE
//   pick_valid         single-cycle pulse: player selected a card
//   *_done             datapath completion pulses for each handshake state
//   match              qualified by verify_done: 1 = the two cards pair up
//   *_req              level requests, high for the whole of the owning state
//   state              encoded current state
//   cur_player         index of the player in turn
//   scores             packed scores, player i at [i*SCORE_W +: SCORE_W]
//   pairs_left         pairs not yet matched
//   time_left          remaining cycles in the current turn
//   winner_mask        players holding the maximum score (valid in DONE)
//   game_over          high in DONE
module memory_game_ctrl #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          NUM_PAIRS   = 8,
  parameter int unsigned TURN_CYCLES = 32'd50_000_000,
  parameter int          EXTRA_TURN  = 1,
  parameter int          SCORE_W     = $clog2(NUM_PAIRS + 1),
  parameter int          PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  parameter int          TW          = $clog2(TURN_CYCLES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           pick_valid,
  input  logic                           show_done,
  input  logic                           hide_done,
  input  logic                           shuffle_done,
  input  logic                           random_done,
  input  logic                           verify_done,
  input  logic                           match,
  output logic                           show_req,
  output logic                           hide_req,
  output logic                           shuffle_req,
  output logic                           random_req,
  output logic                           verify_req,
  output logic [3:0]                     state,
  output logic [PW-1:0]                  cur_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [SCORE_W-1:0]             pairs_left,
  output logic [TW-1:0]                  time_left,
  output logic [NUM_PLAYERS-1:0]         winner_mask,
  output logic                           game_over
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SHOW       = 4'd1,
    S_HIDE       = 4'd2,
    S_SHUFFLE    = 4'd3,
    S_TURN_START = 4'd4,
    S_PICK1      = 4'd5,
    S_PICK2      = 4'd6,
    S_RANDOM     = 4'd7,
    S_VERIFY     = 4'd8,
    S_CHECK_END  = 4'd9,
    S_DONE       = 4'd10
  } state_t;

  state_t                 state_q, state_d;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [PW-1:0]          cur_q;
  logic [SCORE_W-1:0]     pairs_q;
  logic [TW-1:0]          time_q;
  logic [NUM_PLAYERS-1:0] win_q, win_d;
  logic [SCORE_W-1:0]     max_score;
  logic                   keep_turn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and request outputs. Requests decode straight from the state
  // register so they fall with the asynchronous reset.
  always_comb begin
    state_d     = state_q;
    show_req    = 1'b0;
    hide_req    = 1'b0;
    shuffle_req = 1'b0;
    random_req  = 1'b0;
    verify_req  = 1'b0;
    case (state_q)
      S_IDLE:       if (start) state_d = S_SHOW;
      S_SHOW: begin
        show_req = 1'b1;
        if (show_done) state_d = S_HIDE;
      end
      S_HIDE: begin
        hide_req = 1'b1;
        if (hide_done) state_d = S_SHUFFLE;
      end
      S_SHUFFLE: begin
        shuffle_req = 1'b1;
        if (shuffle_done) state_d = S_TURN_START;
      end
      S_TURN_START: state_d = S_PICK1;
      // A pick in the same cycle as timer expiry takes precedence.
      S_PICK1: begin
        if (pick_valid)          state_d = S_PICK2;
        else if (time_q == '0)   state_d = S_RANDOM;
      end
      S_PICK2: begin
        if (pick_valid)          state_d = S_VERIFY;
        else if (time_q == '0)   state_d = S_RANDOM;
      end
      S_RANDOM: begin
        random_req = 1'b1;
        if (random_done) state_d = S_VERIFY;
      end
      S_VERIFY: begin
        verify_req = 1'b1;
        if (verify_done) state_d = S_CHECK_END;
      end
      S_CHECK_END:  state_d = (pairs_q == '0) ? S_DONE : S_TURN_START;
      S_DONE:       if (start) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Single pass over the scores: a new maximum restarts the mask, an equal
  // score adds to it. All-equal scores therefore set every bit.
  always_comb begin
    max_score = '0;
    win_d     = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (score_q[i] > max_score) begin
        max_score = score_q[i];
        win_d     = '0;
        win_d[i]  = 1'b1;
      end else if (score_q[i] == max_score) begin
        win_d[i] = 1'b1;
      end
    end
  end

  assign keep_turn = match && (EXTRA_TURN != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      cur_q   <= '0;
      pairs_q <= SCORE_W'(NUM_PAIRS);
      time_q  <= '0;
      win_q   <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
        cur_q   <= '0;
        pairs_q <= SCORE_W'(NUM_PAIRS);
      end
      if (state_q == S_TURN_START) begin
        time_q <= TW'(TURN_CYCLES);
      end else if ((state_q == S_PICK1 || state_q == S_PICK2) && time_q != '0) begin
        time_q <= time_q - TW'(1);
      end
      if (state_q == S_VERIFY && verify_done) begin
        if (match) begin
          score_q[cur_q] <= score_q[cur_q] + SCORE_W'(1);
          pairs_q        <= pairs_q - SCORE_W'(1);
        end
        if (!keep_turn) begin
          cur_q <= (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + PW'(1);
        end
      end
      if (state_q != S_DONE && state_d == S_DONE)      win_q <= win_d;
      else if (state_q == S_DONE && state_d != S_DONE) win_q <= '0;
    end
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_scores
    assign scores[gi*SCORE_W +: SCORE_W] = score_q[gi];
  end

  assign state       = state_q;
  assign cur_player  = cur_q;
  assign pairs_left  = pairs_q;
  assign time_left   = time_q;
  assign winner_mask = win_q;
  assign game_over   = (state_q == S_DONE);

  // Every pair can be matched only once, so a match with nothing left means
  // the datapath reported a bogus compare.
  a_match_with_pairs_left: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == S_VERIFY && verify_done && match) |-> (pairs_q != '0)
  );

endmodule
